// File: rtl/pcm_stream_ctrl.sv
// rtl/pcm_stream_ctrl.sv - VRAM-to-FIFO PCM sample streamer; buffer looping enabled by PCM_STREAM_LOOP_EN
module pcm_stream_ctrl #(
    parameter int BURST = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [16:0] start_addr,
    input  logic [16:0] length,
    input  logic        loop_en,
    output logic        mem_req,
    output logic [16:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rddata,
    output logic        fifo_reset,
    output logic        fifo_write,
    output logic [7:0]  fifo_wrdata,
    input  logic        fifo_full,
    input  logic        fifo_almost_empty,
    output logic        busy,
    output logic        done_irq
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOW,
        REQ,
        WRITE,
        DONE
    } state_t;

    localparam logic [16:0] BURST_LEN = 17'(BURST);
    localparam logic [6:0]  BURST_CNT = 7'(BURST);

    state_t      state;
    state_t      state_n;
    logic [16:0] addr;
    logic [16:0] remaining;
    logic [6:0]  burst_cnt;
    logic [7:0]  data_q;
    logic        en_q;

    logic        load_start;
    logic        load_burst;
    logic        capture;
    logic        do_write;

`ifdef PCM_STREAM_LOOP_EN
    logic        loop_q;
    logic        do_reload;
`else
    // loop_en has no effect in a build without looping
    wire         unused_loop = loop_en;
`endif

    // State register; reset abandons any burst in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and one-cycle control strobes for the datapath
    always_comb begin
        state_n    = state;
        load_start = 1'b0;
        load_burst = 1'b0;
        capture    = 1'b0;
        do_write   = 1'b0;
`ifdef PCM_STREAM_LOOP_EN
        do_reload  = 1'b0;
`endif
        if (!enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // start only on a rising edge so a finished stream never restarts by itself
                    if (!en_q) begin
                        load_start = 1'b1;
                        state_n    = (length == 17'd0) ? DONE : WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (fifo_almost_empty) begin
                        load_burst = 1'b1;
                        state_n    = REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        capture = 1'b1;
                        state_n = WRITE;
                    end
                end
                WRITE: begin
                    if (!fifo_full) begin
                        do_write = 1'b1;
                        if (remaining == 17'd1) begin
`ifdef PCM_STREAM_LOOP_EN
                            // a reload that finds an empty buffer ends the stream instead
                            if (loop_q && (length != 17'd0)) begin
                                do_reload = 1'b1;
                                state_n   = WAIT_LOW;
                            end else begin
                                state_n = DONE;
                            end
`else
                            state_n = DONE;
`endif
                        end else if (burst_cnt == 7'd1) begin
                            state_n = WAIT_LOW;
                        end else begin
                            state_n = REQ;
                        end
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Stream datapath: buffer pointer, byte counters, captured read data, enable history
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            addr      <= 17'd0;
            remaining <= 17'd0;
            burst_cnt <= 7'd0;
            data_q    <= 8'd0;
`ifdef PCM_STREAM_LOOP_EN
            loop_q    <= 1'b0;
`endif
        end else begin
            en_q <= enable;
            if (load_start) begin
                addr      <= start_addr;
                remaining <= length;
`ifdef PCM_STREAM_LOOP_EN
                loop_q    <= loop_en;
`endif
            end
            if (load_burst) begin
                burst_cnt <= (remaining < BURST_LEN) ? remaining[6:0] : BURST_CNT;
            end
            if (capture) begin
                data_q <= mem_rddata;
            end
            if (do_write) begin
                addr      <= addr + 17'd1;
                remaining <= remaining - 17'd1;
                burst_cnt <= burst_cnt - 7'd1;
            end
`ifdef PCM_STREAM_LOOP_EN
            if (do_reload) begin
                addr      <= start_addr;
                remaining <= length;
                loop_q    <= loop_en;
            end
`endif
        end
    end

    // Outputs decode from state; reset masks them in the cycle it is applied
    always_comb begin
        mem_req     = (state == REQ) && !rst;
        mem_addr    = mem_req ? addr : 17'd0;
        fifo_write  = do_write && !rst;
        fifo_wrdata = rst ? 8'd0 : data_q;
        fifo_reset  = load_start && !rst;
        busy        = (state != IDLE) && !rst;
        done_irq    = (state == DONE) && !rst;
    end

endmodule
